// File: rtl/eva_ahb_pkg.sv
// Shared AHB-Lite encodings and the responder state type for the EVA bus slave.
package eva_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} ahb_slv_st_e;

  function automatic logic [3:0] byte_en(logic [2:0] size, logic [1:0] lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << lo;
      HSIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_mask(logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/eva_ahb_slv_ram.sv
// Word-organised storage with per-byte write enables and an asynchronous read port.
module eva_ahb_slv_ram #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              hclk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge hclk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/eva_ahb_slv_mem.sv
// AHB-Lite memory responder: wait states, sub-word writes, two-cycle ERROR and a
// doorbell interrupt on the last word of the window.
module eva_ahb_slv_mem
  import eva_ahb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned WAIT_CYC  = 0
) (
  input  logic        hclk,
  input  logic        rst_n,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [31:0] haddr,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hready_out,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic        irq
);

  localparam int unsigned Lsb = ADDR_W + 2;

  ahb_slv_st_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              hready_q, ready_d;
  logic [1:0]        hresp_q, resp_d;
  logic              irq_q, irq_d;

  logic [ADDR_W-1:0] idx_q;
  logic [1:0]        lo_q;
  logic [2:0]        size_q;
  logic              write_q;

  logic              take, err_in, out_of_range;
  logic              we;
  logic [3:0]        be;
  logic [31:0]       rdata;
  logic              unused_htrans;

  assign unused_htrans = htrans[0];

  // hready_q is high exactly in the states that can start a new data phase.
  assign take = hsel & htrans[1] & hready_in & hready_q;

  // Base is window-aligned, so comparing the bits above the window is enough.
  assign out_of_range = (haddr >> Lsb) != (BASE_ADDR >> Lsb);
  assign err_in = out_of_range | (hsize > HSIZE_WORD) |
                  ((hsize == HSIZE_HALF) & haddr[0]) |
                  ((hsize == HSIZE_WORD) & (|haddr[1:0]));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hready_q) begin
      if (take) begin
        state_d = err_in ? StErr1 : StData;
        cnt_d   = err_in ? 4'd0 : 4'(WAIT_CYC);
      end else begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    end else if (state_q == StErr1) begin
      state_d = StErr2;
    end else begin
      cnt_d = cnt_q - 4'd1;
    end
    ready_d = (state_d == StIdle) || (state_d == StErr2) ||
              ((state_d == StData) && (cnt_d == 4'd0));
    resp_d  = ((state_d == StErr1) || (state_d == StErr2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  assign we = rst_n & (state_q == StData) & (cnt_q == 4'd0) & write_q;
  assign be = byte_en(size_q, lo_q);

  // Doorbell fires only if the bytes actually written carry a nonzero value.
  assign irq_d = we & (&idx_q) & (|(hwdata & lane_mask(be)));

  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hready_q <= ready_d;
      hresp_q  <= resp_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge hclk) begin
    if (take) begin
      idx_q   <= haddr[Lsb-1:2];
      lo_q    <= haddr[1:0];
      size_q  <= hsize;
      write_q <= hwrite;
    end
  end

  eva_ahb_slv_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .hclk (hclk),
    .we   (we),
    .be   (be),
    .addr (idx_q),
    .wdata(hwdata),
    .rdata(rdata)
  );

  assign hready_out = hready_q;
  assign hresp      = hresp_q;
  assign irq        = irq_q;
  assign hrdata     = ((state_q == StData) && !write_q) ? rdata : 32'h0;

endmodule

// File: tb/tb_eva_ahb_slv_mem.sv
// Scoreboard bench for eva_ahb_slv_mem: three responders with 0, 2 and 3 wait states.
module tb_eva_ahb_slv_mem;
  import eva_ahb_pkg::*;

  localparam int ND = 3;

  logic              hclk = 1'b0;
  logic              rst_n;
  logic [ND-1:0]     hsel;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [31:0]       haddr;
  logic [2:0]        hsize;
  logic [31:0]       hwdata;
  logic [ND-1:0]     hready_out;
  logic [1:0]        hresp  [ND];
  logic [31:0]       hrdata [ND];
  logic [ND-1:0]     irq;

  always #5 hclk = ~hclk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    eva_ahb_slv_mem #(
      .ADDR_W   (10),
      .BASE_ADDR(32'h0000_0000),
      .WAIT_CYC ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .hclk      (hclk),
      .rst_n     (rst_n),
      .hsel      (hsel[g]),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .haddr     (haddr),
      .hsize     (hsize),
      .hwdata    (hwdata),
      .hready_in (hready_out[g]),
      .hready_out(hready_out[g]),
      .hresp     (hresp[g]),
      .hrdata    (hrdata[g]),
      .irq       (irq[g])
    );
  end

  typedef struct {
    int          d;
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic int exp_waits(int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endfunction

  // Monitor: follows each responder's data phases and pops one expectation per completion.
  bit dp     [ND];
  int wcnt   [ND];
  bit lowbad [ND];
  int irq_cnt[ND];

  initial begin
    exp_t e;
    forever begin
      @(negedge hclk);
      for (int i = 0; i < ND; i++) begin
        if (irq[i]) irq_cnt[i]++;
        if (!rst_n) begin
          dp[i]     = 1'b0;
          wcnt[i]   = 0;
          lowbad[i] = 1'b0;
        end else begin
          if (dp[i]) begin
            if (!hready_out[i]) begin
              wcnt[i]++;
              if (sbq.size() > 0 && hresp[i] !== (sbq[0].err ? HRESP_ERROR : HRESP_OKAY))
                lowbad[i] = 1'b1;
            end else if (sbq.size() == 0) begin
              total++;
              bad++;
              $display("FAIL sb_underflow: dut %0d completed with no expectation", i);
              dp[i] = 1'b0;
            end else begin
              e = sbq.pop_front();
              chk("dut_idx", 32'(i), 32'(e.d));
              chk("wait_cycles", 32'(wcnt[i]), 32'(e.err ? 1 : exp_waits(i)));
              chk("hresp", 32'(hresp[i]), 32'(e.err ? HRESP_ERROR : HRESP_OKAY));
              chk("hresp_low", 32'(lowbad[i]), 32'd0);
              chk("hrdata", hrdata[i], (e.rd && !e.err) ? e.data : 32'h0);
              dp[i]     = 1'b0;
              wcnt[i]   = 0;
              lowbad[i] = 1'b0;
            end
          end
          if (hsel[i] && htrans[1] && hready_out[i]) dp[i] = 1'b1;
        end
      end
    end
  end

  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input bit err, input logic [31:0] rd_exp,
                      input bit track);
    bit   rdy;
    int   n;
    exp_t e;
    hsel    = '0;
    hsel[d] = 1'b1;
    htrans  = HTRANS_NONSEQ;
    hwrite  = wr;
    haddr   = a;
    hsize   = sz;
    if (track) begin
      e.d    = d;
      e.err  = err;
      e.rd   = !wr;
      e.data = rd_exp;
      sbq.push_back(e);
    end
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 50) begin
      @(negedge hclk);
      rdy = hready_out[d];
      @(posedge hclk);
      #1;
      n++;
    end
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: dut %0d addr %h", d, a);
    end
    hwdata = wd;
  endtask

  task automatic idle(input int d);
    bit rdy;
    int n;
    hsel   = '0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
    rdy    = 1'b0;
    n      = 0;
    while (!rdy && n < 50) begin
      @(negedge hclk);
      rdy = hready_out[d];
      @(posedge hclk);
      #1;
      n++;
    end
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: dut %0d", d);
    end
  endtask

  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int c0;
    rst_n  = 1'b0;
    hsel   = '0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
    haddr  = '0;
    hsize  = HSIZE_WORD;
    hwdata = '0;
    repeat (3) @(posedge hclk);
    #1;
    for (int i = 0; i < ND; i++) begin
      chk("rst_hready", 32'(hready_out[i]), 32'd1);
      chk("rst_hresp", 32'(hresp[i]), 32'd0);
      chk("rst_hrdata", hrdata[i], 32'h0);
      chk("rst_irq", 32'(irq[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge hclk);
    #1;

    // Zero-wait word/byte/half traffic and errors.
    xfer(0, 1, 32'h100, HSIZE_WORD, 32'hDEADBEEF, 0, 32'h0, 1);
    xfer(0, 0, 32'h100, HSIZE_WORD, 32'h0, 0, 32'hDEADBEEF, 1);
    xfer(0, 1, 32'h104, HSIZE_WORD, 32'h11223344, 0, 32'h0, 1);
    xfer(0, 1, 32'h105, HSIZE_BYTE, 32'h0000AB00, 0, 32'h0, 1);
    xfer(0, 0, 32'h104, HSIZE_WORD, 32'h0, 0, 32'h1122AB44, 1);
    xfer(0, 1, 32'h106, HSIZE_HALF, 32'h55660000, 0, 32'h0, 1);
    xfer(0, 0, 32'h104, HSIZE_WORD, 32'h0, 0, 32'h5566AB44, 1);
    xfer(0, 1, 32'h000, HSIZE_WORD, 32'h00000000, 0, 32'h0, 1);
    xfer(0, 1, 32'h1000, HSIZE_WORD, 32'hBAD0BAD0, 1, 32'h0, 1);
    xfer(0, 0, 32'h000, HSIZE_WORD, 32'h0, 0, 32'h00000000, 1);
    xfer(0, 1, 32'h103, HSIZE_HALF, 32'hFFFFFFFF, 1, 32'h0, 1);
    xfer(0, 0, 32'h100, 3'd3, 32'h0, 1, 32'h0, 1);
    xfer(0, 0, 32'h100, HSIZE_WORD, 32'h0, 0, 32'hDEADBEEF, 1);
    idle(0);

    // Doorbell: pulse timing, overlap with a following accept, and zero-valued writes.
    c0 = irq_cnt[0];
    xfer(0, 1, 32'hFFC, HSIZE_WORD, 32'h00000001, 0, 32'h0, 1);
    chk("irq_early", 32'(irq[0]), 32'd0);
    idle(0);
    chk("irq_pulse", 32'(irq[0]), 32'd1);
    @(posedge hclk);
    #1;
    chk("irq_clear", 32'(irq[0]), 32'd0);
    chk("irq_once", 32'(irq_cnt[0] - c0), 32'd1);

    c0 = irq_cnt[0];
    xfer(0, 1, 32'hFFC, HSIZE_WORD, 32'h00000002, 0, 32'h0, 1);
    xfer(0, 0, 32'hFFC, HSIZE_WORD, 32'h0, 0, 32'h00000002, 1);
    idle(0);
    repeat (2) @(posedge hclk);
    #1;
    chk("irq_overlap", 32'(irq_cnt[0] - c0), 32'd1);

    c0 = irq_cnt[0];
    xfer(0, 1, 32'hFFC, HSIZE_WORD, 32'h00000000, 0, 32'h0, 1);
    xfer(0, 1, 32'hFFD, HSIZE_BYTE, 32'h000000FF, 0, 32'h0, 1);
    xfer(0, 0, 32'hFFC, HSIZE_WORD, 32'h0, 0, 32'h00000000, 1);
    idle(0);
    repeat (2) @(posedge hclk);
    #1;
    chk("irq_zero", 32'(irq_cnt[0] - c0), 32'd0);

    // Two wait states, plus an error that must stay two cycles long.
    xfer(1, 1, 32'h100, HSIZE_WORD, 32'hCAFEF00D, 0, 32'h0, 1);
    xfer(1, 0, 32'h100, HSIZE_WORD, 32'h0, 0, 32'hCAFEF00D, 1);
    xfer(1, 1, 32'h2000, HSIZE_WORD, 32'h00000001, 1, 32'h0, 1);
    xfer(1, 0, 32'h100, HSIZE_WORD, 32'h0, 0, 32'hCAFEF00D, 1);
    idle(1);

    // Reset during a three-wait write drops the write.
    xfer(2, 1, 32'h200, HSIZE_WORD, 32'h12345678, 0, 32'h0, 1);
    idle(2);
    xfer(2, 1, 32'h200, HSIZE_WORD, 32'hFFFFFFFF, 0, 32'h0, 0);
    hsel   = '0;
    htrans = HTRANS_IDLE;
    @(posedge hclk);
    #1;
    rst_n = 1'b0;
    @(posedge hclk);
    #1;
    chk("midrst_hready", 32'(hready_out[2]), 32'd1);
    chk("midrst_hresp", 32'(hresp[2]), 32'd0);
    chk("midrst_hrdata", hrdata[2], 32'h0);
    rst_n = 1'b1;
    @(posedge hclk);
    #1;
    xfer(2, 0, 32'h200, HSIZE_WORD, 32'h0, 0, 32'h12345678, 1);
    idle(2);

    repeat (3) @(posedge hclk);
    #1;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
